// File: rtl/sobel_pkg.sv
// Shared Sobel kernel constants and helpers, used by the streaming and combinational kernels.
package sobel_pkg;

   // Centre taps of each kernel carry weight 2, applied as a left shift.
   localparam int unsigned SOBEL_MID_SHIFT = 1;

   // Vertical rows the window needs before its centre is fully inside the frame.
   localparam int unsigned SOBEL_ROW_FULL = 2;

   // Width of a signed Gx/Gy term: worst case is 4 * (2^data_w - 1) plus a sign bit.
   function automatic int unsigned grad_w(input int unsigned data_w);
      return data_w + 3;
   endfunction

   // |gx| + |gy| clamped to the largest out_w-bit unsigned value.
   function automatic int unsigned sat_abs_sum(input int gx, input int gy,
                                               input int unsigned out_w);
      int unsigned ax;
      int unsigned ay;
      int unsigned mag;
      int unsigned max_v;
      ax    = (gx < 0) ? int'(-gx) : int'(gx);
      ay    = (gy < 0) ? int'(-gy) : int'(gy);
      mag   = ax + ay;
      max_v = (32'd1 << out_w) - 32'd1;
      return (mag > max_v) ? max_v : mag;
   endfunction

endpackage

// File: rtl/sobel_stream_if.sv
// Pixel-in / magnitude-out stream handshake bundle for sobel_stream.
interface sobel_stream_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned OUT_W  = 8
);
   logic              in_valid;
   logic              in_ready;
   logic              in_sof;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [OUT_W-1:0]  out_data;

   // Source of pixels and sink of magnitudes.
   modport master (
      output in_valid, in_sof, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   // The Sobel block itself.
   modport slave (
      input  in_valid, in_sof, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/sobel_line_buf.sv
// One image line of delay: read-before-write at the column address on every enabled cycle.
// Contents are never cleared; the caller masks stale rows.
module sobel_line_buf #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned IMG_W  = 640,
   localparam int unsigned AW    = $clog2(IMG_W)
) (
   input  logic              clk,
   input  logic              en,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout
);
   logic [DATA_W-1:0] mem [IMG_W];

   // Old value at this column is presented while the new one is written at the edge.
   assign dout = mem[addr];

   // Store the incoming pixel on each enabled cycle.
   always_ff @(posedge clk) begin
      if (en) begin
         mem[addr] <= din;
      end
   end
endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge magnitude: one raster pixel in, one saturated |Gx|+|Gy| out,
// one cycle of latency. Define SOBEL_THRESH_EN to add a thresh port and emit a binary edge map.
module sobel_stream
   import sobel_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned OUT_W  = 8,
   parameter int unsigned IMG_W  = 640
) (
   input logic             clk,
   input logic             rst_n,
`ifdef SOBEL_THRESH_EN
   input logic [OUT_W-1:0] thresh,
`endif
   sobel_stream_if.slave   bus
);
   localparam int unsigned GW = grad_w(DATA_W);
   localparam int unsigned CW = $clog2(IMG_W);

   logic              accept;
   logic [CW-1:0]     col_q;
   logic [CW-1:0]     col_eff;
   logic [1:0]        row_q;
   logic [1:0]        row_eff;
   logic [DATA_W-1:0] lb0_rd;
   logic [DATA_W-1:0] lb1_rd;
   // Per window row, [0] holds column c-1 and [1] column c-2; column c is live.
   logic [DATA_W-1:0] top_q [2];
   logic [DATA_W-1:0] mid_q [2];
   logic [DATA_W-1:0] bot_q [2];
   logic signed [GW-1:0] gx;
   logic signed [GW-1:0] gy;
   logic [OUT_W-1:0]  sat_mag;
   logic              border;
   logic [OUT_W-1:0]  result;
   logic              out_valid_q;
   logic [OUT_W-1:0]  out_data_q;

   function automatic logic signed [GW-1:0] ext(input logic [DATA_W-1:0] v);
      return $signed({{(GW - DATA_W){1'b0}}, v});
   endfunction

   assign bus.in_ready  = !out_valid_q || bus.out_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign accept        = bus.in_valid && bus.in_ready;

   // A start-of-frame pixel is placed at (0,0) regardless of where the counters stood.
   assign col_eff = bus.in_sof ? '0 : col_q;
   assign row_eff = bus.in_sof ? '0 : row_q;

   // Raster position; row only needs to know whether two full lines are behind us.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q <= '0;
         row_q <= '0;
      end else if (accept) begin
         if (col_eff == CW'(IMG_W - 1)) begin
            col_q <= '0;
            row_q <= (row_eff == 2'(SOBEL_ROW_FULL)) ? row_eff : row_eff + 2'd1;
         end else begin
            col_q <= col_eff + CW'(1);
            row_q <= row_eff;
         end
      end
   end

   sobel_line_buf #(
      .DATA_W (DATA_W),
      .IMG_W  (IMG_W)
   ) u_lb0 (
      .clk  (clk),
      .en   (accept),
      .addr (col_eff),
      .din  (bus.in_data),
      .dout (lb0_rd)
   );

   sobel_line_buf #(
      .DATA_W (DATA_W),
      .IMG_W  (IMG_W)
   ) u_lb1 (
      .clk  (clk),
      .en   (accept),
      .addr (col_eff),
      .din  (lb0_rd),
      .dout (lb1_rd)
   );

   // Shift the newest column into the window on every accept, border or not.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         top_q <= '{default: '0};
         mid_q <= '{default: '0};
         bot_q <= '{default: '0};
      end else if (accept) begin
         top_q[1] <= top_q[0];
         top_q[0] <= lb1_rd;
         mid_q[1] <= mid_q[0];
         mid_q[0] <= lb0_rd;
         bot_q[1] <= bot_q[0];
         bot_q[0] <= bus.in_data;
      end
   end

   // Kernel on the window p0..p8; right column and bottom-right come straight from the inputs.
   always_comb begin
      gx = (ext(lb1_rd) + (ext(lb0_rd) <<< SOBEL_MID_SHIFT) + ext(bus.in_data))
         - (ext(top_q[1]) + (ext(mid_q[1]) <<< SOBEL_MID_SHIFT) + ext(bot_q[1]));
      gy = (ext(bot_q[1]) + (ext(bot_q[0]) <<< SOBEL_MID_SHIFT) + ext(bus.in_data))
         - (ext(top_q[1]) + (ext(top_q[0]) <<< SOBEL_MID_SHIFT) + ext(lb1_rd));
      sat_mag = OUT_W'(sat_abs_sum(int'(gx), int'(gy), OUT_W));
   end

   // Centre on the top row or left column, or a window straddling a line wrap, reads as zero.
   always_comb begin
      border = (row_eff != 2'(SOBEL_ROW_FULL)) || (col_eff < CW'(2));
`ifdef SOBEL_THRESH_EN
      result = (border || (sat_mag < thresh)) ? '0 : '1;
`else
      result = border ? '0 : sat_mag;
`endif
   end

   // Output register: load on accept, otherwise empty once the sink has taken the value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         out_data_q  <= result;
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end
endmodule

// File: tb/tb_sobel_stream.sv
// Self-checking bench for sobel_stream: directed frames on an 8-pixel-wide image, a 2-D
// reference kernel, a table of hand-computed pixels and sequences for stall, sof and reset.
module tb_sobel_stream;
   localparam int unsigned DW = 8;
   localparam int unsigned OW = 8;
   localparam int unsigned IW = 8;
   localparam int          THR = 50;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sobel_stream_if #(.DATA_W(DW), .OUT_W(OW)) bus ();
`ifdef SOBEL_THRESH_EN
   logic [OW-1:0] thresh;
`endif

   sobel_stream #(
      .DATA_W (DW),
      .OUT_W  (OW),
      .IMG_W  (IW)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
`ifdef SOBEL_THRESH_EN
      .thresh (thresh),
`endif
      .bus    (bus.slave)
   );

   typedef struct { int r; int c; int exp; } pos_t;
   typedef struct { int pat; int r; int c; int exp; } vec_t;

   pos_t exp_q[$];
   vec_t vecs[16];
   int   checks = 0;
   int   passed = 0;
   int   cur [16][IW];
   int   got_img [16][IW];
   int   mr, mc, n_in, n_out;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   function automatic int apply_thr(input int m);
`ifdef SOBEL_THRESH_EN
      return (m >= THR) ? 255 : 0;
`else
      return m;
`endif
   endfunction

   // Reference kernel over the bench's own copy of the frame, centred on (r-1,c-1).
   function automatic int model(input int r, input int c);
      int gx, gy, m;
      if (r < 2 || c < 2) return 0;
      gx = (cur[r-2][c] + 2 * cur[r-1][c] + cur[r][c])
         - (cur[r-2][c-2] + 2 * cur[r-1][c-2] + cur[r][c-2]);
      gy = (cur[r][c-2] + 2 * cur[r][c-1] + cur[r][c])
         - (cur[r-2][c-2] + 2 * cur[r-2][c-1] + cur[r-2][c]);
      m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      if (m > 255) m = 255;
      return apply_thr(m);
   endfunction

   function automatic int pat_px(input int pat, input int r, input int c);
      case (pat)
         1:       return 100;
         2:       return (c >= 4) ? 255 : 0;
         default: return (r == 3 && c == 3) ? 10 : 0;
      endcase
   endfunction

   // Scoreboard: every output transfer must match the oldest outstanding pixel.
   always @(negedge clk) begin
      pos_t e;
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            check("extra_output", 1, 0);
         end else begin
            e = exp_q.pop_front();
            got_img[e.r][e.c] = int'(bus.out_data);
            n_out++;
            check($sformatf("pix(%0d,%0d)", e.r, e.c), int'(bus.out_data), e.exp);
         end
      end
   end

   task automatic send_pixel(input int d, input bit sof);
      int   n;
      pos_t t;
      n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(d);
      bus.in_sof   = sof;
      @(negedge clk);
      while (!bus.in_ready) begin
         n++;
         if (n > 50) begin
            $display("FAIL accept_timeout: in_ready stuck at %0d, expected 1", bus.in_ready);
            $fatal(1, "input never accepted");
         end
         @(negedge clk);
      end
      if (sof) begin
         mr = 0;
         mc = 0;
      end
      cur[mr][mc] = d;
      t.r = mr;
      t.c = mc;
      t.exp = model(mr, mc);
      exp_q.push_back(t);
      n_in++;
      mc++;
      if (mc == IW) begin
         mc = 0;
         mr++;
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
   endtask

   task automatic send_frame(input int pat, input int rows, input bit sof_first);
      for (int i = 0; i < rows * IW; i++)
         send_pixel(pat_px(pat, i / IW, i % IW), sof_first && (i == 0));
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 20) begin
         @(posedge clk);
         #2;
         n++;
      end
      check(name, exp_q.size(), 0);
   endtask

   task automatic clear_got();
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < int'(IW); c++) got_img[r][c] = -1;
   endtask

   task automatic run_table(input int pat, input string tag);
      for (int i = 0; i < 16; i++)
         if (vecs[i].pat == pat)
            check($sformatf("%s(%0d,%0d)", tag, vecs[i].r, vecs[i].c),
                  got_img[vecs[i].r][vecs[i].c], apply_thr(vecs[i].exp));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time %0t, expected completion earlier", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      vecs = '{
         '{1, 2, 2, 0},   '{1, 5, 7, 0},   '{1, 0, 0, 0},
         '{2, 2, 4, 255}, '{2, 2, 5, 255}, '{2, 4, 4, 255}, '{2, 5, 5, 255},
         '{2, 3, 3, 0},   '{2, 5, 6, 0},   '{2, 1, 5, 0},   '{2, 3, 1, 0},
         '{3, 3, 3, 20},  '{3, 3, 4, 20},  '{3, 4, 4, 0},   '{3, 5, 4, 20}, '{3, 2, 2, 0}
      };
      bus.in_valid  = 1'b0;
      bus.in_sof    = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
`ifdef SOBEL_THRESH_EN
      thresh = OW'(THR);
`endif
      mr = 0; mc = 0; n_in = 0; n_out = 0;

      // Reset state, in_ready driven purely by an empty output register.
      #12;
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_out_data", int'(bus.out_data), 0);
      bus.out_ready = 1'b0;
      #1;
      check("rst_in_ready", int'(bus.in_ready), 1);
      bus.out_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Flat frame.
      clear_got();
      n_in = 0; n_out = 0;
      send_frame(1, 6, 1'b1);
      drain("flat_drain");
      check("flat_count", n_out, n_in);
      run_table(1, "flat");

      // Vertical edge.
      clear_got();
      send_frame(2, 6, 1'b1);
      drain("edge_drain");
      run_table(2, "edge");

      // Single dot.
      clear_got();
      send_frame(3, 6, 1'b1);
      drain("dot_drain");
      run_table(3, "dot");

      // Backpressure: hold the (2,4) result for 5 cycles while the next pixel waits.
      clear_got();
      n_in = 0; n_out = 0;
      for (int i = 0; i < 6 * int'(IW); i++) begin
         if (i == 21) begin
            bus.out_ready = 1'b0;
            bus.in_valid  = 1'b1;
            bus.in_data   = DW'(pat_px(2, i / IW, i % IW));
            for (int k = 0; k < 5; k++) begin
               @(negedge clk);
               check("bp_in_ready", int'(bus.in_ready), 0);
               check("bp_out_valid", int'(bus.out_valid), 1);
               check("bp_hold", int'(bus.out_data), (exp_q.size() > 0) ? exp_q[0].exp : -1);
               @(posedge clk);
               #1;
            end
            bus.out_ready = 1'b1;
         end
         send_pixel(pat_px(2, i / IW, i % IW), i == 0);
      end
      drain("bp_drain");
      check("bp_count", n_out, n_in);
      run_table(2, "bp_edge");

      // in_sof mid-line at (4,5) of an edge frame, followed by a full dot frame.
      clear_got();
      for (int i = 0; i < 4 * int'(IW) + 5; i++)
         send_pixel(pat_px(2, i / IW, i % IW), i == 0);
      send_frame(3, 6, 1'b1);
      drain("sof_drain");
      run_table(3, "sof_dot");

      // Asynchronous reset mid-frame, then a frame without in_sof.
      clear_got();
      for (int i = 0; i < 20; i++)
         send_pixel(pat_px(2, i / IW, i % IW), i == 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", int'(bus.out_valid), 0);
      check("arst_out_data", int'(bus.out_data), 0);
      exp_q.delete();
      mr = 0;
      mc = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      clear_got();
      send_frame(2, 6, 1'b0);
      drain("arst_drain");
      run_table(2, "arst_edge");

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
